// File: rtl/cv32e40p_irq_pending_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_pkg
// Brief    : Shared constants for the IRQ pending unit (line mask, reg map).
// Revision : 1.0
// ============================================================================
package cv32e40p_pkg;

    // Implemented lines: MSI=3, MTI=7, MEI=11, fast interrupts 16-31
    localparam logic [31:0] IRQPU_IRQ_MASK = 32'hFFFF_0888;

    localparam logic [2:0] IRQPU_EDGE     = 3'd0;
    localparam logic [2:0] IRQPU_ENABLE   = 3'd1;
    localparam logic [2:0] IRQPU_PEND     = 3'd2;
    localparam logic [2:0] IRQPU_PEND_CLR = 3'd3;
    localparam logic [2:0] IRQPU_OVF      = 3'd4;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_irq_pending_unit_sync.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_irq_sync
// Brief    : Multi-bit, SYNC_STAGES-deep flop synchronizer, async reset.
// Revision : 1.0
// ============================================================================
module cv32e40p_irq_sync #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q_o = r_stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cv32e40p_irq_pending_unit.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_irq_pending_unit
// Brief    : Edge/level interrupt pending logic driving the CV32E40P irq vector.
// Revision : 1.0
// ============================================================================
module cv32e40p_irq_pending_unit
    import cv32e40p_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] IRQ_MASK    = IRQPU_IRQ_MASK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] src_i,
    output logic [31:0] irq_o,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_id_i,
    input  logic        cfg_we_i,
    input  logic [2:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o
);

    logic [31:0] w_s;
    logic [31:0] r_s_q;
    logic [31:0] r_edge;
    logic [31:0] r_enable;
    logic [31:0] r_pend;
    logic [31:0] r_ovf;

    logic [31:0] w_rise;
    logic [31:0] w_wdata_m;
    logic [31:0] w_ack_vec;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [31:0] w_ovf_set;
    logic [31:0] w_pend;

    cv32e40p_irq_sync #(
        .WIDTH       (32),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (src_i & IRQ_MASK),
        .q_o (w_s)
    );

    assign w_rise    = w_s & ~r_s_q & IRQ_MASK;
    assign w_wdata_m = cfg_wdata_i & IRQ_MASK;
    assign w_ack_vec = irq_ack_i ? (32'd1 << irq_id_i) : 32'd0;

    // Set and clear only ever touch edge lines; set dominates so no event is lost.
    assign w_set = (w_rise
                  | ((cfg_we_i && cfg_addr_i == IRQPU_PEND) ? w_wdata_m : 32'd0))
                  & r_edge;
    assign w_clr = (w_ack_vec
                  | ((cfg_we_i && cfg_addr_i == IRQPU_PEND_CLR) ? w_wdata_m : 32'd0))
                  & r_edge;

    assign w_ovf_set = w_rise & r_edge & r_pend & ~w_clr;

    // Level lines bypass the stored bit and follow the synchronized source.
    assign w_pend = ((r_pend & r_edge) | (w_s & ~r_edge)) & IRQ_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_q    <= '0;
            r_edge   <= '0;
            r_enable <= '0;
            r_pend   <= '0;
            r_ovf    <= '0;
            irq_o    <= '0;
        end else begin
            r_s_q <= w_s;
            // Masking by the current EDGE drops the bit when a line turns level
            // and guarantees a line turning edge starts from zero.
            r_pend <= ((r_pend & ~w_clr) | w_set) & r_edge;
            if (cfg_we_i && cfg_addr_i == IRQPU_OVF) begin
                r_ovf <= (r_ovf & ~w_wdata_m) | w_ovf_set;
            end else begin
                r_ovf <= r_ovf | w_ovf_set;
            end
            if (cfg_we_i && cfg_addr_i == IRQPU_EDGE) begin
                r_edge <= w_wdata_m;
            end
            if (cfg_we_i && cfg_addr_i == IRQPU_ENABLE) begin
                r_enable <= w_wdata_m;
            end
            irq_o <= w_pend & r_enable & IRQ_MASK;
        end
    end

    always_comb begin
        cfg_rdata_o = 32'd0;
        case (cfg_addr_i)
            IRQPU_EDGE:   cfg_rdata_o = r_edge;
            IRQPU_ENABLE: cfg_rdata_o = r_enable;
            IRQPU_PEND:   cfg_rdata_o = w_pend;
            IRQPU_OVF:    cfg_rdata_o = r_ovf;
            default:      cfg_rdata_o = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_irq_pending_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_irq_pending_unit
// Brief    : Directed self-checking bench for cv32e40p_irq_pending_unit.
// Revision : 1.0
// ============================================================================
module tb_cv32e40p_irq_pending_unit;

    logic        clk;
    logic        rst;
    logic [31:0] src_i;
    logic [31:0] irq_o;
    logic        irq_ack_i;
    logic [4:0]  irq_id_i;
    logic        cfg_we_i;
    logic [2:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;

    int n_cmp;
    int n_bad;

    cv32e40p_irq_pending_unit #(
        .SYNC_STAGES (2),
        .IRQ_MASK    (32'hFFFF_0888)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_i       (src_i),
        .irq_o       (irq_o),
        .irq_ack_i   (irq_ack_i),
        .irq_id_i    (irq_id_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_wdata_i (cfg_wdata_i),
        .cfg_rdata_o (cfg_rdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [31:0] data);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = addr;
        cfg_wdata_i = data;
        tick(1);
        cfg_we_i    = 1'b0;
        cfg_wdata_i = 32'd0;
    endtask

    task automatic cfg_read(input logic [2:0] addr, output logic [31:0] data);
        cfg_addr_i = addr;
        #1;
        data = cfg_rdata_o;
    endtask

    task automatic pulse(input int line);
        src_i[line] = 1'b1;
        tick(3);
        src_i[line] = 1'b0;
        tick(3);
    endtask

    task automatic ack(input logic [4:0] id);
        irq_ack_i = 1'b1;
        irq_id_i  = id;
        tick(1);
        irq_ack_i = 1'b0;
        irq_id_i  = 5'd0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst   = 1'b1;
        src_i = 32'hFFFF_FFFF;
        tick(4);
        n_cmp++;
        if (irq_o !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_irq: got %h want %h", irq_o, 32'd0);
        end
        for (int a = 0; a < 8; a++) begin
            cfg_read(3'(a), rd);
            n_cmp++;
            if (rd !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_rd addr%0d: got %h want %h", a, rd, 32'd0);
            end
        end
        src_i = 32'd0;
        tick(1);
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_edge_latency;
        logic [31:0] rd;
        cfg_write(3'd0, 32'h800);
        cfg_write(3'd1, 32'h800);
        src_i[11] = 1'b1;
        tick(3);
        src_i[11] = 1'b0;
        n_cmp++;
        if (irq_o !== 32'd0) begin
            n_bad++;
            $display("FAIL edge_lat_early: got %h want %h", irq_o, 32'd0);
        end
        tick(1);
        n_cmp++;
        if (irq_o !== 32'h800) begin
            n_bad++;
            $display("FAIL edge_lat_4clk: got %h want %h", irq_o, 32'h800);
        end
        tick(2);
        ack(5'd11);
        n_cmp++;
        if (irq_o !== 32'h800) begin
            n_bad++;
            $display("FAIL edge_ack_stale: got %h want %h", irq_o, 32'h800);
        end
        tick(1);
        n_cmp++;
        if (irq_o !== 32'd0) begin
            n_bad++;
            $display("FAIL edge_ack_drop: got %h want %h", irq_o, 32'd0);
        end
        cfg_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL edge_no_ovf: got %h want %h", rd, 32'd0);
        end
    endtask

    task automatic test_ovf;
        logic [31:0] rd;
        cfg_write(3'd0, 32'h10000);
        cfg_write(3'd1, 32'h10000);
        pulse(16);
        cfg_read(3'd2, rd);
        n_cmp++;
        if (rd !== 32'h10000) begin
            n_bad++;
            $display("FAIL ovf_pend_first: got %h want %h", rd, 32'h10000);
        end
        pulse(16);
        cfg_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'h10000) begin
            n_bad++;
            $display("FAIL ovf_set: got %h want %h", rd, 32'h10000);
        end
        cfg_write(3'd4, 32'h10000);
        cfg_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL ovf_w1c: got %h want %h", rd, 32'd0);
        end
        // The rise is visible two edges after src goes high; ack lands on that cycle.
        src_i[16] = 1'b1;
        tick(2);
        ack(5'd16);
        cfg_read(3'd2, rd);
        n_cmp++;
        if (rd !== 32'h10000) begin
            n_bad++;
            $display("FAIL ack_vs_rise_pend: got %h want %h", rd, 32'h10000);
        end
        cfg_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL ack_vs_rise_ovf: got %h want %h", rd, 32'd0);
        end
        src_i[16] = 1'b0;
        tick(3);
        cfg_write(3'd3, 32'h10000);
        cfg_read(3'd2, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL pend_clr: got %h want %h", rd, 32'd0);
        end
        tick(1);
    endtask

    task automatic test_level;
        cfg_write(3'd0, 32'd0);
        cfg_write(3'd1, 32'h80);
        tick(2);
        src_i[7] = 1'b1;
        tick(2);
        n_cmp++;
        if (irq_o !== 32'd0) begin
            n_bad++;
            $display("FAIL level_rise_early: got %h want %h", irq_o, 32'd0);
        end
        tick(1);
        n_cmp++;
        if (irq_o !== 32'h80) begin
            n_bad++;
            $display("FAIL level_rise: got %h want %h", irq_o, 32'h80);
        end
        ack(5'd7);
        tick(1);
        n_cmp++;
        if (irq_o !== 32'h80) begin
            n_bad++;
            $display("FAIL level_ack_ignored: got %h want %h", irq_o, 32'h80);
        end
        src_i[7] = 1'b0;
        tick(2);
        n_cmp++;
        if (irq_o !== 32'h80) begin
            n_bad++;
            $display("FAIL level_fall_early: got %h want %h", irq_o, 32'h80);
        end
        tick(1);
        n_cmp++;
        if (irq_o !== 32'd0) begin
            n_bad++;
            $display("FAIL level_fall: got %h want %h", irq_o, 32'd0);
        end
    endtask

    task automatic test_pend_write;
        logic [31:0] rd;
        cfg_write(3'd0, 32'hFFFF_FFFF);
        cfg_write(3'd1, 32'd0);
        cfg_write(3'd2, 32'hFFFF_FFFF);
        cfg_read(3'd2, rd);
        n_cmp++;
        if (rd !== 32'hFFFF_0888) begin
            n_bad++;
            $display("FAIL pend_w1s: got %h want %h", rd, 32'hFFFF_0888);
        end
        cfg_read(3'd0, rd);
        n_cmp++;
        if (rd !== 32'hFFFF_0888) begin
            n_bad++;
            $display("FAIL edge_masked: got %h want %h", rd, 32'hFFFF_0888);
        end
        cfg_read(3'd3, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL pend_clr_reads0: got %h want %h", rd, 32'd0);
        end
        cfg_write(3'd5, 32'hFFFF_FFFF);
        cfg_read(3'd5, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL addr5_reads0: got %h want %h", rd, 32'd0);
        end
        n_cmp++;
        if (irq_o !== 32'd0) begin
            n_bad++;
            $display("FAIL pend_disabled: got %h want %h", irq_o, 32'd0);
        end
        cfg_write(3'd1, 32'hFFFF_FFFF);
        tick(1);
        n_cmp++;
        if (irq_o !== 32'hFFFF_0888) begin
            n_bad++;
            $display("FAIL pend_enabled: got %h want %h", irq_o, 32'hFFFF_0888);
        end
        ack(5'd4);
        tick(1);
        n_cmp++;
        if (irq_o !== 32'hFFFF_0888) begin
            n_bad++;
            $display("FAIL ack_unimpl: got %h want %h", irq_o, 32'hFFFF_0888);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        // Line 3 is already pending from the PEND write, so a new rise overflows it.
        pulse(3);
        cfg_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'h8) begin
            n_bad++;
            $display("FAIL pre_rst_ovf: got %h want %h", rd, 32'h8);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (irq_o !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_async_irq: got %h want %h", irq_o, 32'd0);
        end
        cfg_read(3'd2, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_async_pend: got %h want %h", rd, 32'd0);
        end
        cfg_read(3'd4, rd);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_async_ovf: got %h want %h", rd, 32'd0);
        end
        tick(1);
        rst = 1'b0;
        tick(1);
        cfg_write(3'd0, 32'h800);
        cfg_write(3'd1, 32'h800);
        src_i[11] = 1'b1;
        tick(3);
        n_cmp++;
        if (irq_o !== 32'd0) begin
            n_bad++;
            $display("FAIL post_rst_early: got %h want %h", irq_o, 32'd0);
        end
        tick(1);
        n_cmp++;
        if (irq_o !== 32'h800) begin
            n_bad++;
            $display("FAIL post_rst_lat: got %h want %h", irq_o, 32'h800);
        end
        src_i[11] = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        src_i       = 32'd0;
        irq_ack_i   = 1'b0;
        irq_id_i    = 5'd0;
        cfg_we_i    = 1'b0;
        cfg_addr_i  = 3'd0;
        cfg_wdata_i = 32'd0;
        test_reset();
        test_edge_latency();
        test_ovf();
        test_level();
        test_pend_write();
        test_reset_mid();
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
